// File: rtl/e_mdu_ctrl_pkg.sv
// ============================================================================
// Module   : e_mdu_ctrl_pkg
// Purpose  : Shared op codes, default latencies and FSM encoding for the MDU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package e_mdu_ctrl_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  localparam int MDU_MULT_CYCLES_DFLT = 5;
  localparam int MDU_DIV_CYCLES_DFLT  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for several cycles and therefore stall D.
  function automatic logic mdu_is_long(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/e_mdu_ctrl_arith.sv
// ============================================================================
// Module   : mdu_arith
// Purpose  : Combinational 64-bit product / quotient-remainder for the MDU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_arith
  import e_mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic        w_signed;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_divisor;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_signed = (op == MDU_MULT) || (op == MDU_DIV);

  // The low 64 bits of a 64x64 product of sign-extended operands equal the
  // signed 32x32 product, so one multiplier serves both mult flavours.
  assign w_a_ext = {{32{w_signed & a[31]}}, a};
  assign w_b_ext = {{32{w_signed & b[31]}}, b};
  assign w_prod  = w_a_ext * w_b_ext;

  assign div0 = (b == 32'd0);

  // Magnitude divide then sign fix-up; 0x80000000 / -1 falls out naturally
  // as 0x80000000 rem 0 because the magnitude of INT_MIN is representable
  // unsigned and both signs cancel.
  assign w_a_mag   = (w_signed & a[31]) ? (32'd0 - a) : a;
  assign w_b_mag   = (w_signed & b[31]) ? (32'd0 - b) : b;
  assign w_divisor = div0 ? 32'd1 : w_b_mag;
  assign w_q_mag   = w_a_mag / w_divisor;
  assign w_r_mag   = w_a_mag % w_divisor;
  assign w_q       = (w_signed & (a[31] ^ b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r       = (w_signed & a[31]) ? (32'd0 - w_r_mag) : w_r_mag;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MDU_MULT, MDU_MULTU: begin
        res_hi = w_prod[63:32];
        res_lo = w_prod[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        res_hi = w_r;
        res_lo = w_q;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/e_mdu_ctrl.sv
// ============================================================================
// Module   : e_mdu_ctrl
// Purpose  : E-stage multiply/divide sequencer holding HI/LO, with stall req.
//            Optional MDU_FLUSH_EN adds a flush input that cancels an op.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DFLT,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DFLT
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic             busy_q, busy_d;

  logic             w_flush;
  logic             w_start_ok;
  logic             w_start_long;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_div0;

`ifdef MDU_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_start_ok   = start & ~w_flush;
  assign w_start_long = start & mdu_is_long(op);

  mdu_arith u_arith (
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (w_res_hi),
    .res_lo (w_res_lo),
    .div0   (w_div0)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (w_start_ok) begin
          if (mdu_is_long(op)) begin
            pend_hi_d = w_res_hi;
            pend_lo_d = w_res_lo;
            // A divide by zero still burns its cycles but must not commit.
            pend_wr_d = ~(mdu_is_div(op) & w_div0);
            cnt_d     = mdu_is_div(op) ? C_DIV_CNT : C_MULT_CNT;
            state_d   = ST_RUN;
            busy_d    = 1'b1;
          end else if (op == MDU_MTHI) begin
            hi_d = a;
          end else if (op == MDU_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_RUN: begin
        if (w_flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == C_CNT_ONE) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = '0;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      busy_q    <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = d_md_use & (busy_q | w_start_long);

endmodule

`default_nettype wire

// File: tb/tb_e_mdu_ctrl.sv
// ============================================================================
// Module   : tb_e_mdu_ctrl
// Purpose  : Self-checking bench for e_mdu_ctrl against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_e_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        d_md_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        m_flush;
`ifdef MDU_FLUSH_EN
  logic        flush = 1'b0;
  assign m_flush = flush;
`else
  assign m_flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  e_mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef MDU_FLUSH_EN
    .flush     (flush),
`endif
    .start     (start),
    .op        (op_i),
    .a         (a_i),
    .b         (b_i),
    .d_md_use  (d_md_use),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: {commit_ok, hi, lo} straight from the arithmetic rules.
  function automatic logic [64:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned p;
    logic [63:0]     v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sb; v = p; return {1'b1, v}; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; v = p; return {1'b1, v}; end
      3'd3: begin
        if (b == 32'd0) return {1'b0, 64'd0};
        q = sa / sb;
        r = sa % sb;
        return {1'b1, r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return {1'b0, 64'd0};
        return {1'b1, a % b, a / b};
      end
      default: return {1'b0, 64'd0};
    endcase
  endfunction

  // Model: remaining busy cycles plus pending result.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [64:0] m_pend = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left != 0 && m_flush) begin
      m_left <= 0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_pend[64]) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (start && !m_flush) begin
      if (op_i >= 3'd1 && op_i <= 3'd4) begin
        m_pend <= calc(op_i, a_i, b_i);
        m_left <= (op_i >= 3'd3) ? DIV_N : MULT_N;
      end else if (op_i == 3'd5) begin
        m_hi <= a_i;
      end else if (op_i == 3'd6) begin
        m_lo <= a_i;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_left != 0});
      chk("stall_req", {31'd0, stall_req},
          {31'd0, d_md_use & ((m_left != 0) | (start & (op_i >= 3'd1) & (op_i <= 3'd4)))});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic idle_inputs();
    start = 1'b0; op_i = 3'd0; a_i = '0; b_i = '0; d_md_use = 1'b0;
  endtask

  // Issue one op and count the busy cycles that follow (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmu, output int n);
    @(posedge clk); #1;
    start = 1'b1; op_i = op; a_i = a; b_i = b; d_md_use = dmu;
    if (dmu) begin
      #1 chk("stall_at_start", {31'd0, stall_req}, {31'd0, (op >= 3'd1) && (op <= 3'd4)});
    end
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    d_md_use = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, n);
    chk("mult_cycles", n, MULT_N);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    run_op(3'd4, 32'd7, 32'd2, 1'b0, n);
    chk("divu_cycles", n, DIV_N);
    chk("divu_hi", hi, 32'd1);
    chk("divu_lo", lo, 32'd3);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, n);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n);
    chk("div_ovf_hi", hi, 32'd0);
    chk("div_ovf_lo", lo, 32'h8000_0000);

    run_op(3'd5, 32'h11, 32'd0, 1'b1, n);
    chk("mthi_nobusy", n, 0);
    chk("mthi_hi", hi, 32'h11);
    run_op(3'd6, 32'h22, 32'd0, 1'b0, n);
    run_op(3'd3, 32'd9, 32'd0, 1'b0, n);
    chk("div0_cycles", n, DIV_N);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    // Reset in the middle of a multiply
    @(posedge clk); #1;
    start = 1'b1; op_i = 3'd1; a_i = 32'd5; b_i = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("rstrun_busy", {31'd0, busy}, 32'd0);
    chk("rstrun_hi", hi, 32'd0);
    chk("rstrun_lo", lo, 32'd0);
    repeat (8) @(posedge clk);
    #1 chk("rstrun_nocommit", lo, 32'd0);

`ifdef MDU_FLUSH_EN
    run_op(3'd5, 32'hAA, 32'd0, 1'b0, n);
    @(posedge clk); #1;
    start = 1'b1; op_i = 3'd2; a_i = 32'hFFFF_FFFF; b_i = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, 32'hAA);
    chk("flush_lo", lo, 32'd0);

    @(posedge clk); #1;
    start = 1'b1; op_i = 3'd1; a_i = 32'd3; b_i = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (MULT_N - 1) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_commit_busy", {31'd0, busy}, 32'd0);
    chk("flush_commit_lo", lo, 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      start    = ($urandom_range(0, 2) == 0);
      op_i     = 3'($urandom_range(0, 7));
      a_i      = pick();
      b_i      = pick();
      d_md_use = 1'($urandom_range(0, 1));
      reset    = ($urandom_range(0, 99) == 0);
`ifdef MDU_FLUSH_EN
      flush    = ($urandom_range(0, 29) == 0);
`endif
    end
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b0;
`ifdef MDU_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (DIV_N + 2) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/e_mdu_ctrl.md
Name: e_mdu_ctrl

Overview:
- Multiply/divide sequencer for the E stage of the 5-stage pipeline.
- Accepts one MDU op per start pulse, holds the HI/LO result registers, and models the multi-cycle latency with a countdown.
- Drives a stall request to the hazard/stall controller so a D-stage MDU instruction waits while a prior op is in flight.
- mfhi/mflo read hi/lo combinationally in E. W-stage writeback is unchanged.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high; clears all state on the rising edge of clk
- start  input  1  E-stage instruction is an MDU op; one-cycle qualifier
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
- a  input  32  forwarded rs value
- b  input  32  forwarded rt value
- d_md_use  input  1  D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo
- busy  output  1  op in flight
- stall_req  output  1  = d_md_use & (busy | start_long); start_long = start & op in 1..4
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset values: hi=0, lo=0, busy=0, stall_req=0 (given d_md_use=0), counter=0, state IDLE.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter>0.
- IDLE, start, op in {MULT,MULTU,DIV,DIVU}:
  - compute result into pend_hi/pend_lo at that edge;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
  - busy rises the cycle after start.
- RUN: counter decrements each cycle. When counter==1:
  - next edge commits pend_hi/pend_lo to hi/lo, counter=0, go to IDLE.
  - busy is high for exactly N cycles.
- MTHI/MTLO in IDLE: hi<=a or lo<=a at that edge; no busy; no stall contribution.
- start while RUN: ignored (stall_req guarantees it cannot occur). hi/lo and counter are unaffected.
- op NONE or op>6 with start=1: no effect.
- Arithmetic:
  - MULT: signed 32x32 to 64, hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32 to 64, same split.
  - DIV: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
- Divide by zero (b==0): the op still takes DIV_CYCLES busy cycles, and hi/lo are left unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- hi/lo are visible to E-stage mfhi/mflo combinationally. Values reflect only committed ops; the pending result is never forwarded.
- reset asserted mid-RUN: the op is abandoned, pend is discarded, and all outputs return to reset values next edge.

Optional Feature:
- Macro: MDU_FLUSH_EN.
- With it defined, an extra input `flush` (1 bit) exists.
  - flush=1 in RUN: state goes to IDLE and the counter clears next edge; hi/lo are NOT updated.
  - flush=1 concurrent with start: start is dropped.
  - flush outranks commit on the same edge.
- Without it: no port, no cancel path.

Decomposition:
- Shared package:
  - MDU op code constants (MDU_NONE..MDU_MTLO, 3-bit);
  - default MULT_CYCLES/DIV_CYCLES constants;
  - state encoding (IDLE/RUN).
- Sub-module mdu_arith: combinational 64-bit product and quotient/remainder from op, a, b. Includes divide-by-zero and overflow handling and a div0 flag.
- e_mdu_ctrl keeps the FSM, counter, pend and HI/LO registers.

Test Plan:
- Reset mid-run: issue MULT, assert reset on cycle 3 -> next cycle busy=0, hi=0, lo=0; no later commit.
- Signed multiply:
  - stimulus: MULT a=0xFFFFFFFE (-2), b=3.
  - busy=1 for exactly 5 cycles starting the cycle after start.
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - hi/lo hold their old value during busy.
- Divide and overflow corner:
  - DIVU a=7, b=2 -> after 10 busy cycles lo=3, hi=1.
  - DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIV b=0 -> busy 10 cycles, hi=0x11, lo=0x22.
- Stall request:
  - d_md_use=1 in the same cycle as a MULT start -> stall_req=1.
  - stall_req stays 1 through all 5 busy cycles and drops the cycle busy falls.
  - MTHI start with d_md_use=1 -> stall_req=0, hi=a next edge.
- Flush (MDU_FLUSH_EN): start MULTU 0xFFFFFFFF*2, flush on 2nd busy cycle -> busy=0 next edge, hi/lo unchanged.
- Flush priority: flush on the commit cycle -> no update.
